// File: rtl/mult_error_monitor_if.sv
// Sample stream from the approximate multiplier into the error monitor.
interface mult_error_monitor_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [15:0] approx_p;

  modport master (output in_valid, op_a, op_b, approx_p, input in_ready);
  modport slave  (input in_valid, op_a, op_b, approx_p, output in_ready);
endinterface

// File: rtl/mult_error_monitor.sv
// Collects |exact - approx| statistics over a run of N_SAMPLES accepted samples
// through a three-stage pipeline (capture, diff, accumulate).
module mult_error_monitor #(
  parameter int N_SAMPLES = 256,
  parameter int ACC_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  mult_error_monitor_if.slave  smp,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          err_cnt,
  output logic [ACC_W-1:0]     err_sum,
  output logic [15:0]          max_err,
  output logic [7:0]           max_a,
  output logic [7:0]           max_b
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [15:0] LAST = 16'(N_SAMPLES - 1);
  localparam int          SW   = ((ACC_W > 16) ? ACC_W : 16) + 1;
  localparam logic [SW-1:0] SAT = SW'({ACC_W{1'b1}});

  state_t      state, state_nxt;
  logic [15:0] acc_cnt;
  logic [1:0]  drain_cnt;
  logic        beat, clear;

  logic        s1_v, s2_v;
  logic [7:0]  s1_a, s1_b, s2_a, s2_b;
  logic [15:0] s1_p, s2_diff;
  logic [15:0] exact, diff_c;
  logic signed [16:0] delta;
  logic [SW-1:0] sum_ext;

  assign beat  = smp.in_valid & smp.in_ready;
  assign clear = (state == IDLE) & start;

  always_comb begin
    state_nxt    = state;
    smp.in_ready = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        smp.in_ready = 1'b1;
        busy         = 1'b1;
        if (beat && acc_cnt == LAST) state_nxt = DRAIN;
      end
      // Held until the third edge after the final beat so done follows the S3 update.
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == 2'd2) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (clear)     acc_cnt <= '0;
      else if (beat) acc_cnt <= acc_cnt + 16'd1;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : '0;
    end
  end

  always_comb begin
    exact   = 16'(s1_a) * 16'(s1_b);
    delta   = $signed({1'b0, exact}) - $signed({1'b0, s1_p});
    diff_c  = delta[16] ? 16'(-delta) : delta[15:0];
    sum_ext = SW'(err_sum) + SW'(s2_diff);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_p    <= '0;
      s2_v    <= 1'b0;
      s2_a    <= '0;
      s2_b    <= '0;
      s2_diff <= '0;
    end else begin
      s1_v <= beat;
      if (beat) begin
        s1_a <= smp.op_a;
        s1_b <= smp.op_b;
        s1_p <= smp.approx_p;
      end
      s2_v <= s1_v;
      if (s1_v) begin
        s2_a    <= s1_a;
        s2_b    <= s1_b;
        s2_diff <= diff_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
      err_sum <= '0;
      max_err <= '0;
      max_a   <= '0;
      max_b   <= '0;
    end else if (clear) begin
      err_cnt <= '0;
      err_sum <= '0;
      max_err <= '0;
      max_a   <= '0;
      max_b   <= '0;
    end else if (s2_v) begin
      if (s2_diff != '0 && err_cnt != '1) err_cnt <= err_cnt + 16'd1;
      err_sum <= (sum_ext > SAT) ? '1 : sum_ext[ACC_W-1:0];
      if (s2_diff > max_err) begin
        max_err <= s2_diff;
        max_a   <= s2_a;
        max_b   <= s2_b;
      end
    end
  end

endmodule

// File: tb/tb_mult_error_monitor.sv
// Randomized and directed runs on four monitor configurations, checked against
// a list-based reference computed from the accepted samples.
module tb_mult_error_monitor;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } smp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  start = '0;
  logic        valid = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic [15:0] p = '0;

  logic        ready_o[4], busy_o[4], done_o[4];
  logic [15:0] cnt_o[4], mx_o[4];
  logic [31:0] sum_o[4];
  logic [7:0]  ma_o[4], mb_o[4];

  int n_chk = 0, n_pass = 0;
  smp_t smp_q[$], exp_q[$];
  bit   sv_q[$];

  always #5 clk = ~clk;

  function automatic int ns_of(input int d);
    return (d == 0) ? 4 : (d == 1) ? 3 : (d == 2) ? 2 : 1;
  endfunction

  function automatic int aw_of(input int d);
    return (d == 2) ? 8 : (d == 3) ? 16 : 32;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int NSG = (g == 0) ? 4 : (g == 1) ? 3 : (g == 2) ? 2 : 1;
    localparam int AWG = (g == 2) ? 8 : (g == 3) ? 16 : 32;
    mult_error_monitor_if ifc ();
    logic [AWG-1:0] sum_w;
    assign ifc.in_valid = valid;
    assign ifc.op_a     = a;
    assign ifc.op_b     = b;
    assign ifc.approx_p = p;
    assign ready_o[g]   = ifc.in_ready;
    assign sum_o[g]     = 32'(sum_w);
    mult_error_monitor #(.N_SAMPLES(NSG), .ACC_W(AWG)) dut (
      .clk(clk), .rst(rst), .start(start[g]), .smp(ifc),
      .busy(busy_o[g]), .done(done_o[g]), .err_cnt(cnt_o[g]), .err_sum(sum_w),
      .max_err(mx_o[g]), .max_a(ma_o[g]), .max_b(mb_o[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic chk_zero(input int d);
    chk("z_rdy", ready_o[d], 0);
    chk("z_busy", busy_o[d], 0);
    chk("z_done", done_o[d], 0);
    chk("z_cnt", cnt_o[d], 0);
    chk("z_sum", sum_o[d], 0);
    chk("z_max", mx_o[d], 0);
    chk("z_ma", ma_o[d], 0);
    chk("z_mb", mb_o[d], 0);
  endtask

  // Reference: statistics recomputed from scratch over the accepted-sample list.
  task automatic model_chk(input int d);
    int cnt = 0, mx = 0, ma = 0, mb = 0;
    longint sum = 0;
    longint satmax = (64'd1 << aw_of(d)) - 1;
    foreach (exp_q[i]) begin
      int df = int'(exp_q[i].a) * int'(exp_q[i].b) - int'(exp_q[i].p);
      if (df < 0) df = -df;
      if (df != 0) cnt++;
      sum += df;
      if (sum > satmax) sum = satmax;
      if (df > mx) begin
        mx = df;
        ma = int'(exp_q[i].a);
        mb = int'(exp_q[i].b);
      end
    end
    chk("err_cnt", cnt_o[d], cnt);
    chk("err_sum", sum_o[d], sum);
    chk("max_err", mx_o[d], mx);
    chk("max_a", ma_o[d], ma);
    chk("max_b", mb_o[d], mb);
  endtask

  task automatic add(input int xa, input int xb, input int xp);
    smp_t s;
    s.a = 8'(xa);
    s.b = 8'(xb);
    s.p = 16'(xp);
    smp_q.push_back(s);
  endtask

  task automatic gen_rand(input int n);
    int ones = 0;
    smp_q.delete();
    sv_q.delete();
    for (int i = 0; i < n; i++) begin
      int xa = $urandom_range(0, 255);
      int xb = $urandom_range(0, 255);
      int e  = xa * xb;
      case ($urandom_range(0, 3))
        0: add(xa, xb, e);
        1: add(xa, xb, e + $urandom_range(0, 40));
        2: add(xa, xb, e - $urandom_range(0, 40));
        default: add(xa, xb, $urandom_range(0, 65535));
      endcase
    end
    while (ones < n) begin
      bit v = ($urandom_range(0, 3) != 0);
      sv_q.push_back(v);
      ones += v ? 1 : 0;
    end
  endtask

  task automatic run_stim(input int d, input bit hold_start);
    int n = ns_of(d);
    int i = 0, j = 0, beats = 0;
    exp_q.delete();
    @(negedge clk);
    valid = 1'b1; a = 8'hFF; b = 8'hFF; p = '0;
    start[d] = 1'b1;
    chk("idle_rdy", ready_o[d], 0);
    @(negedge clk);
    start[d] = hold_start;
    while (beats < n && i < sv_q.size()) begin
      valid = sv_q[i];
      a = smp_q[j].a; b = smp_q[j].b; p = smp_q[j].p;
      chk("run_rdy", ready_o[d], 1);
      chk("run_busy", busy_o[d], 1);
      if (sv_q[i]) begin
        exp_q.push_back(smp_q[j]);
        j++;
        beats++;
      end
      i++;
      @(negedge clk);
    end
    chk("beats", beats, n);
    valid = 1'b1; a = 8'hFF; b = 8'hFF; p = '0;
    for (int c = 0; c < 3; c++) begin
      chk("drain_rdy", ready_o[d], 0);
      chk("drain_busy", busy_o[d], 1);
      chk("drain_done", done_o[d], 0);
      if (c == 2) start[d] = 1'b0;
      @(negedge clk);
    end
    chk("done_hi", done_o[d], 1);
    chk("done_busy", busy_o[d], 0);
    chk("done_rdy", ready_o[d], 0);
    model_chk(d);
    valid = 1'b0;
    @(negedge clk);
    chk("done_lo", done_o[d], 0);
    chk("idle_busy", busy_o[d], 0);
    model_chk(d);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) chk_zero(d);
    rst = 1'b0;

    // exact products give zero statistics
    smp_q.delete(); sv_q = '{1, 1, 1, 1};
    add(3, 5, 15); add(0, 255, 0); add(255, 255, 65025); add(16, 16, 256);
    run_stim(0, 1'b0);

    // equal errors: earlier sample keeps max
    smp_q.delete(); sv_q = '{1, 1, 1};
    add(255, 255, 65000); add(200, 100, 20025); add(10, 10, 95);
    run_stim(1, 1'b0);

    // gaps in valid
    smp_q.delete(); sv_q = '{1, 0, 0, 1, 1, 0, 1};
    for (int k = 0; k < 4; k++) add(7, 9, 60);
    run_stim(0, 1'b0);

    // 8-bit accumulator saturation
    smp_q.delete(); sv_q = '{1, 1};
    add(255, 255, 0); add(1, 1, 0);
    run_stim(2, 1'b0);

    // reset after two of four beats
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    valid = 1'b1; a = 8'd200; b = 8'd200; p = '0;
    repeat (2) @(negedge clk);
    valid = 1'b0;
    rst = 1'b1;
    #2;
    chk_zero(0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk("rst_nodone", done_o[0], 0);
      chk("rst_nobusy", busy_o[0], 0);
      @(negedge clk);
    end
    gen_rand(4);
    run_stim(0, 1'b0);

    // start held through RUN and DRAIN
    gen_rand(3);
    run_stim(1, 1'b1);

    // randomized runs on every configuration
    for (int r = 0; r < 12; r++) begin
      int d = r % 4;
      gen_rand(ns_of(d));
      run_stim(d, r[2]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
